btb_predictor: RTL and testbench
================================

# btb_predictor

Parametrised branch target buffer with direction prediction for the fetch stage. It is set-associative with configurable depth and associativity. Each entry holds a tag, a target and a 2-bit saturating direction counter. Fetch gets a same-cycle prediction (hit, taken, next PC). The execute stage writes back resolved control transfers through a single update port, which trains the counters and allocates or replaces entries with per-set round-robin replacement.

## Interface
Parameters:
- SETS_LOG2, 4: log2 of set count; index = pc[SETS_LOG2+1:2], tag = pc[31:SETS_LOG2+2].
- WAYS, 2: associativity; power of two, 1..8.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- lookup_pc  in  32  fetch PC to predict.
- lookup_valid  in  1  lookup qualifier.
- pred_hit  out  1  tag match in a valid way of the indexed set.
- pred_taken  out  1  pred_hit && counter[1].
- pred_next_pc  out  32  pred_taken ? stored target : lookup_pc + 4.
- upd_valid  in  1  resolved control transfer this cycle.
- upd_pc  in  32  PC of the resolved instruction.
- upd_taken  in  1  actual direction.
- upd_target  in  32  actual target (used only when upd_taken).
- flush  in  1  invalidate all entries.

## Operation
- Storage per entry: valid, tag (32-SETS_LOG2-2 bits), target[31:0] and ctr[1:0]. Each set also has a replacement pointer of log2(WAYS) bits (no pointer when WAYS=1).
- Lookup is purely combinational from the stored state.
  - lookup_valid=0: pred_hit=0, pred_taken=0, pred_next_pc=lookup_pc+4.
  - Multiple matching ways cannot arise by construction. If they do, the lowest way index wins.
- Update, when upd_valid=1 with no rst and no flush: index and tag are taken from upd_pc.
  - Hit in way w:
    - ctr saturating-increments if upd_taken (max 2'b11) and saturating-decrements otherwise (min 2'b00).
    - If upd_taken, target is overwritten with upd_target.
    - The replacement pointer is unchanged.
  - Miss with upd_taken=1: allocate the victim way.
    - Victim is the lowest-indexed invalid way. If all ways are valid, the victim is the way at the replacement pointer, and the pointer then increments modulo WAYS.
    - Filling an invalid way does not move the pointer.
    - The new entry gets valid=1, tag, target=upd_target and ctr=2'b10.
  - Miss with upd_taken=0: no state change.
- Address arithmetic: +4 is modulo 2^32, so 0xFFFFFFFC becomes 0x00000000. upd_pc[1:0] and lookup_pc[1:0] are ignored.
- flush: clears every valid bit and every replacement pointer. Targets, tags and counters may be left unchanged.
- rst: clears all valid bits, pointers and counters.
- Priority: rst > flush > update.

## Timing
- Lookup latency is 0 cycles (combinational). Outputs settle within the same cycle as lookup_pc.
- Update becomes visible to lookup on the cycle after the edge that samples upd_valid.
- A lookup in the same cycle as an update to the same entry sees the pre-update contents. There is no bypass.
- Update accepts one request per cycle with no backpressure. Back-to-back updates to the same set apply in order, each seeing the prior one's result.
- Reset values: all entries are invalid, so the first cycle after rst deasserts gives pred_hit=0, pred_taken=0, pred_next_pc=lookup_pc+4.
- rst or flush asserted together with upd_valid discards the update; no allocation occurs.
- rst asserted for 1 cycle is sufficient. Asserting it mid-stream (during any update) leaves no partial state.

## Test plan
Run with SETS_LOG2=4 and WAYS=2. PCs 0x100, 0x140, 0x180 and 0x1C0 all map to set 0.
- **Cold miss:** after rst, lookup 0x100 -> pred_hit=0, pred_taken=0, pred_next_pc=0x104. Lookup 0xFFFFFFFC -> next 0x00000000.
- **Allocate and bypass check:** update 0x100 taken, target 0x200.
  - Same-cycle lookup 0x100 -> miss.
  - Next cycle -> hit=1, taken=1, next=0x200.
- **Counter training:** starting from the allocation above (ctr=10):
  - Not-taken update -> ctr 01; lookup gives hit=1, taken=0, next=0x104.
  - Two more not-taken -> ctr 00 (saturates).
  - Taken with target 0x300 -> ctr 01, still not taken; target is now 0x300.
  - Second taken -> ctr 10, next=0x300.
  - A fifth taken update saturates at 11.
- **Replacement:**
  - Allocate 0x100 (way0) then 0x140 (way1); pointer stays 0.
  - Allocate 0x180 -> evicts way0; pointer becomes 1. Lookup 0x100 misses; 0x140 and 0x180 hit.
  - Allocate 0x1C0 -> evicts 0x140.
- **Flush priority:** with entries valid, assert flush together with a taken update of 0x240. Next cycle every lookup (0x100, 0x240) misses.
- **Reset mid-operation:** assert rst with upd_valid=1 (0x100 taken). Next cycle lookup 0x100 -> miss. Subsequent allocations fill way0 first.

Source files
------------

// File: rtl/btb_predictor.sv
// rtl/btb_predictor.sv - set-associative branch target buffer with 2-bit direction counters
// Combinational fetch lookup; single execute update port with per-set round-robin replacement.
module btb_predictor #(
    parameter int SETS_LOG2 = 4,
    parameter int WAYS      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lookup_pc,
    input  logic        lookup_valid,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_next_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        flush
);
    localparam int SETS  = 1 << SETS_LOG2;
    localparam int TAG_W = 32 - SETS_LOG2 - 2;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [WAY_W-1:0] PTR_MAX = WAY_W'(WAYS - 1);

    logic [WAYS-1:0]  r_valid  [SETS];
    logic [TAG_W-1:0] r_tag    [SETS][WAYS];
    logic [31:0]      r_target [SETS][WAYS];
    logic [1:0]       r_ctr    [SETS][WAYS];
    logic [WAY_W-1:0] r_ptr    [SETS];

    logic [SETS_LOG2-1:0] w_lk_idx;
    logic [TAG_W-1:0]     w_lk_tag;
    logic                 w_lk_match;
    logic [31:0]          w_lk_target;
    logic [1:0]           w_lk_ctr;

    logic [SETS_LOG2-1:0] w_up_idx;
    logic [TAG_W-1:0]     w_up_tag;
    logic                 w_up_hit;
    logic [WAY_W-1:0]     w_up_way;
    logic                 w_has_inv;
    logic [WAY_W-1:0]     w_inv_way;
    logic [WAY_W-1:0]     w_victim;
    logic [WAY_W-1:0]     w_ptr_next;
    logic                 w_unused_lsbs;

    assign w_unused_lsbs = ^upd_pc[1:0];

    // Ways are scanned high to low so the lowest matching way is the one left standing.
    always_comb begin
        w_lk_idx    = lookup_pc[SETS_LOG2+1:2];
        w_lk_tag    = lookup_pc[31:SETS_LOG2+2];
        w_lk_match  = 1'b0;
        w_lk_target = '0;
        w_lk_ctr    = 2'b00;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_lk_idx][w] && r_tag[w_lk_idx][w] == w_lk_tag) begin
                w_lk_match  = 1'b1;
                w_lk_target = r_target[w_lk_idx][w];
                w_lk_ctr    = r_ctr[w_lk_idx][w];
            end
        end
    end

    assign pred_hit     = lookup_valid && w_lk_match;
    assign pred_taken   = pred_hit && w_lk_ctr[1];
    assign pred_next_pc = pred_taken ? w_lk_target : lookup_pc + 32'd4;

    always_comb begin
        w_up_idx  = upd_pc[SETS_LOG2+1:2];
        w_up_tag  = upd_pc[31:SETS_LOG2+2];
        w_up_hit  = 1'b0;
        w_up_way  = '0;
        w_has_inv = 1'b0;
        w_inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_up_idx][w] && r_tag[w_up_idx][w] == w_up_tag) begin
                w_up_hit = 1'b1;
                w_up_way = WAY_W'(w);
            end
            if (!r_valid[w_up_idx][w]) begin
                w_has_inv = 1'b1;
                w_inv_way = WAY_W'(w);
            end
        end
        w_victim   = w_has_inv ? w_inv_way : r_ptr[w_up_idx];
        w_ptr_next = (r_ptr[w_up_idx] == PTR_MAX) ? '0 : r_ptr[w_up_idx] + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_ptr[s]   <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    r_ctr[s][w] <= 2'b00;
                end
            end
        end else if (flush) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_ptr[s]   <= '0;
            end
        end else if (upd_valid) begin
            if (w_up_hit) begin
                if (upd_taken) begin
                    r_target[w_up_idx][w_up_way] <= upd_target;
                    if (r_ctr[w_up_idx][w_up_way] != 2'b11) begin
                        r_ctr[w_up_idx][w_up_way] <= r_ctr[w_up_idx][w_up_way] + 2'b01;
                    end
                end else if (r_ctr[w_up_idx][w_up_way] != 2'b00) begin
                    r_ctr[w_up_idx][w_up_way] <= r_ctr[w_up_idx][w_up_way] - 2'b01;
                end
            end else if (upd_taken) begin
                r_valid[w_up_idx][w_victim]  <= 1'b1;
                r_tag[w_up_idx][w_victim]    <= w_up_tag;
                r_target[w_up_idx][w_victim] <= upd_target;
                r_ctr[w_up_idx][w_victim]    <= 2'b10;
                // Only a full set advances round-robin; filling a hole leaves it alone.
                if (!w_has_inv) begin
                    r_ptr[w_up_idx] <= w_ptr_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_btb_predictor.sv
// tb/tb_btb_predictor.sv - directed self-checking bench for btb_predictor
module tb_btb_predictor;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] lookup_pc;
    logic        lookup_valid;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_next_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        flush;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    btb_predictor #(.SETS_LOG2(4), .WAYS(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .lookup_pc    (lookup_pc),
        .lookup_valid (lookup_valid),
        .pred_hit     (pred_hit),
        .pred_taken   (pred_taken),
        .pred_next_pc (pred_next_pc),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .upd_target   (upd_target),
        .flush        (flush)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                        input logic taken, input logic [31:0] nxt);
        lookup_pc    = pc;
        lookup_valid = 1'b1;
        #1;
        check({tag, ".hit"}, {31'b0, pred_hit}, {31'b0, hit});
        check({tag, ".taken"}, {31'b0, pred_taken}, {31'b0, taken});
        check({tag, ".next"}, pred_next_pc, nxt);
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = taken;
        upd_target = tgt;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        upd_target = '0; lookup_pc = '0; lookup_valid = 1'b0;
        @(posedge clk);
        pulse_rst();

        look("cold", 32'h100, 1'b0, 1'b0, 32'h104);
        look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

        // Same-cycle lookup must see the pre-update state.
        @(negedge clk);
        upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h200;
        look("bypass", 32'h100, 1'b0, 1'b0, 32'h104);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        look("alloc", 32'h100, 1'b1, 1'b1, 32'h200);
        lookup_valid = 1'b0;
        #1;
        check("lv0.hit", {31'b0, pred_hit}, 32'h0);
        check("lv0.next", pred_next_pc, 32'h104);

        upd(32'h100, 1'b0, 32'h0);
        look("ctr01", 32'h100, 1'b1, 1'b0, 32'h104);
        upd(32'h100, 1'b0, 32'h0);
        upd(32'h100, 1'b0, 32'h0);
        look("ctr00", 32'h100, 1'b1, 1'b0, 32'h104);
        upd(32'h100, 1'b1, 32'h300);
        look("ctr00to01", 32'h100, 1'b1, 1'b0, 32'h104);
        upd(32'h100, 1'b1, 32'h300);
        look("ctr10", 32'h100, 1'b1, 1'b1, 32'h300);
        upd(32'h100, 1'b1, 32'h300);
        upd(32'h100, 1'b1, 32'h300);
        upd(32'h100, 1'b0, 32'h0);
        look("sat11_dec", 32'h100, 1'b1, 1'b1, 32'h300);
        upd(32'h100, 1'b0, 32'h0);
        look("ctr01b", 32'h100, 1'b1, 1'b0, 32'h104);

        pulse_rst();
        upd(32'h100, 1'b1, 32'h310);
        upd(32'h140, 1'b1, 32'h340);
        look("rep.w0", 32'h100, 1'b1, 1'b1, 32'h310);
        look("rep.w1", 32'h140, 1'b1, 1'b1, 32'h340);
        upd(32'h180, 1'b1, 32'h380);
        look("rep.ev100", 32'h100, 1'b0, 1'b0, 32'h104);
        look("rep.keep140", 32'h140, 1'b1, 1'b1, 32'h340);
        look("rep.new180", 32'h180, 1'b1, 1'b1, 32'h380);
        upd(32'h1C0, 1'b1, 32'h3C0);
        look("rep.ev140", 32'h140, 1'b0, 1'b0, 32'h144);
        look("rep.keep180", 32'h180, 1'b1, 1'b1, 32'h380);
        look("rep.new1c0", 32'h1C0, 1'b1, 1'b1, 32'h3C0);
        upd(32'h240, 1'b0, 32'h0);
        look("nt_miss", 32'h240, 1'b0, 1'b0, 32'h244);
        upd(32'h104, 1'b1, 32'h500);
        look("set1", 32'h104, 1'b1, 1'b1, 32'h500);
        look("set0_intact", 32'h180, 1'b1, 1'b1, 32'h380);
        // Evicts 0x180 in way0 and leaves the pointer at 1 before the flush.
        upd(32'h240, 1'b1, 32'h600);
        look("pre_flush", 32'h240, 1'b1, 1'b1, 32'h600);

        flush = 1'b1;
        upd(32'h280, 1'b1, 32'h700);
        flush = 1'b0;
        look("fl.240", 32'h240, 1'b0, 1'b0, 32'h244);
        look("fl.1c0", 32'h1C0, 1'b0, 1'b0, 32'h1C4);
        look("fl.104", 32'h104, 1'b0, 1'b0, 32'h108);
        look("fl.280", 32'h280, 1'b0, 1'b0, 32'h284);
        upd(32'h100, 1'b1, 32'h110);
        upd(32'h140, 1'b1, 32'h150);
        upd(32'h180, 1'b1, 32'h190);
        look("fl.ptr_ev100", 32'h100, 1'b0, 1'b0, 32'h104);
        look("fl.ptr_keep140", 32'h140, 1'b1, 1'b1, 32'h150);

        // Pointer is 1 here; reset must return it to 0 and drop the concurrent update.
        rst = 1'b1;
        upd(32'h100, 1'b1, 32'h900);
        rst = 1'b0;
        look("rst.100", 32'h100, 1'b0, 1'b0, 32'h104);
        look("rst.140", 32'h140, 1'b0, 1'b0, 32'h144);
        upd(32'h180, 1'b1, 32'hA00);
        upd(32'h1C0, 1'b1, 32'hB00);
        upd(32'h100, 1'b1, 32'hC00);
        look("rst.ev180", 32'h180, 1'b0, 1'b0, 32'h184);
        look("rst.keep1c0", 32'h1C0, 1'b1, 1'b1, 32'hB00);
        look("rst.new100", 32'h100, 1'b1, 1'b1, 32'hC00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
